// File: rtl/cache_mem_responder_if.sv
// Request/valid handshake bundle between a cache master and its memory responder.
// The bidirectional data word travels on a separate inout port of the responder.
interface cache_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]        operation;
  logic [ADDR_W-1:0] addr;
  logic              request;
  logic              valid;

  modport master (output operation, output addr, output request, input valid);
  modport slave  (input operation, input addr, input request, output valid);
endinterface

// File: rtl/cache_mem_responder.sv
// Fixed-latency word memory answering one 4-phase request at a time.
// Define CACHE_RESP_COUNTERS_EN to add the read_count/write_count ports.
module cache_mem_responder #(
  parameter int WORD_W     = 8,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                clock,
  input  logic                reset,
  cache_mem_responder_if.slave bus,
  inout  wire  [WORD_W-1:0]   data
`ifdef CACHE_RESP_COUNTERS_EN
  ,
  output logic [15:0]         read_count,
  output logic [15:0]         write_count
`endif
);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND,
    RELEASE
  } state_e;

  state_e                  state;
  logic [7:0]              cnt;
  op_e                     op_q;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [WORD_W-1:0]       wdata_q;
  logic [WORD_W-1:0]       rdata_q;
  logic                    valid_q;
  logic                    drive_en;
  logic                    commit;
  logic                    mem_we;
  logic                    addr_unused;

  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Upper address bits alias onto the same words.
  assign addr_unused = ^bus.addr[ADDR_W-1:DEPTH_LOG2];

  assign commit = (state == BUSY) && bus.request && (cnt == 8'd0);
  assign mem_we = commit && (op_q == OP_WRITE);

  assign bus.valid = valid_q;
  assign data      = drive_en ? rdata_q : 'z;

  // NOTE: the memory array has no reset; clearing it would turn it into flops and its contents are defined only once written.
  always_ff @(posedge clock) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      op_q        <= OP_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      drive_en    <= 1'b0;
`ifdef CACHE_RESP_COUNTERS_EN
      read_count  <= 16'd0;
      write_count <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.request) begin
            op_q    <= op_e'(bus.operation);
            addr_q  <= bus.addr[DEPTH_LOG2-1:0];
            wdata_q <= data;
            cnt     <= 8'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.request) begin
            // Master withdrew before completion: discard the operation.
            cnt   <= 8'd0;
            state <= IDLE;
          end else if (cnt == 8'd0) begin
            if (op_q == OP_READ) begin
              rdata_q  <= mem[addr_q];
              drive_en <= 1'b1;
            end
`ifdef CACHE_RESP_COUNTERS_EN
            if (op_q == OP_READ)  read_count  <= read_count + 16'd1;
            if (op_q == OP_WRITE) write_count <= write_count + 16'd1;
`endif
            valid_q <= 1'b1;
            state   <= RESPOND;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESPOND: begin
          if (!bus.request) begin
            valid_q  <= 1'b0;
            drive_en <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
